// File: rtl/rs_segment_sequencer.sv
// Purpose : sequences Reed-Solomon segments (gap, data bytes, parity or decoder wait) for one job.
// Latency : a source byte appears on synDataI the cycle after its srcValid/srcReady handshake.
// Backpressure: srcReady drops in every issue cycle (max one byte per two cycles); a stalled source holds the accept cycle.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start, encode, abort       - job start (encode sampled with start), job cancel (highest priority)
//   busy, done, segIndex       - job active, one-cycle completion pulse, current segment number
//   srcData/srcBlank/srcValid/srcReady - byte source with per-byte erasure flag
//   sinkData/sinkValid         - parity bytes returned by the syndrome block (encode mode)
//   syn*                       - syndrome/encoder side: run/mode/end-of-segment/data/valid/erasure
//   synDataO, rsDone           - parity byte from encoder, decoder finished with segment
// Build option: define RS_SEQ_STATS_EN to add saturating byteCount/segCount outputs.
module rs_segment_sequencer #(
    parameter int DATA_LEN = 172,
    parameter int PAR_LEN  = 4,
    parameter int SEG_NUM  = 3,
    parameter int GAP      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       encode,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [1:0] segIndex,
    input  logic [7:0] srcData,
    input  logic       srcBlank,
    input  logic       srcValid,
    output logic       srcReady,
    output logic [7:0] sinkData,
    output logic       sinkValid,
    output logic       synRunning,
    output logic       synEncoding,
    output logic       synEndSegment,
    output logic [7:0] synDataI,
    output logic       synValid,
    output logic       synBlanking,
    input  logic [7:0] synDataO,
    input  logic       rsDone
`ifdef RS_SEQ_STATS_EN
    ,
    output logic [15:0] byteCount,
    output logic [7:0]  segCount
`endif
);

    localparam int TOTAL_MAX = DATA_LEN + PAR_LEN;
    localparam int CNT_W     = $clog2(TOTAL_MAX + 1);
    localparam int GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int PAR_W     = (PAR_LEN > 0) ? $clog2(PAR_LEN + 1) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GAP     = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_WAIT_RS = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // With no gap configured a segment starts directly in DATA.
    localparam logic [2:0]       S_SEG_ENTRY = (GAP == 0) ? S_DATA : S_GAP;
    localparam logic [1:0]       LAST_SEG    = 2'(SEG_NUM - 1);
    localparam logic [CNT_W-1:0] LEN_ENC     = CNT_W'(DATA_LEN);
    localparam logic [CNT_W-1:0] LEN_DEC     = CNT_W'(TOTAL_MAX);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [PAR_W-1:0] PAR_END     = PAR_W'(PAR_LEN);

    logic [2:0]       state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [PAR_W-1:0] par_cnt_q, par_cnt_d;
    logic [1:0]       seg_idx_q, seg_idx_d;
    logic             encoding_q, encoding_d;
    logic             syn_valid_q, syn_valid_d;
    logic [7:0]       syn_data_q, syn_data_d;
    logic             syn_blank_q, syn_blank_d;
    logic             syn_end_q, syn_end_d;
    logic             par_pulse_q, par_pulse_d;   // current synValid pulse is a parity request
    logic             sink_vld_q, sink_vld_d;

    logic [CNT_W-1:0] seg_len;
    logic             src_rdy;
    logic             end_segment;

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        par_cnt_d   = par_cnt_q;
        seg_idx_d   = seg_idx_q;
        encoding_d  = encoding_q;
        syn_valid_d = 1'b0;
        syn_data_d  = 8'h00;
        syn_blank_d = 1'b0;
        syn_end_d   = 1'b0;
        par_pulse_d = 1'b0;
        sink_vld_d  = par_pulse_q;
        src_rdy     = 1'b0;
        end_segment = 1'b0;
        seg_len     = encoding_q ? LEN_ENC : LEN_DEC;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SEG_ENTRY;
                    encoding_d = encode;
                    seg_idx_d  = 2'd0;
                    gap_cnt_d  = '0;
                    byte_cnt_d = '0;
                    par_cnt_d  = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_DATA;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DATA: begin
                // Ready only in accept cycles; the issue cycle is marked by syn_valid_q.
                src_rdy = ~syn_valid_q;
                if (src_rdy && srcValid) begin
                    syn_valid_d = 1'b1;
                    syn_data_d  = srcData;
                    syn_blank_d = srcBlank;
                    byte_cnt_d  = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == seg_len - CNT_W'(1)) begin
                        syn_end_d = 1'b1;
                        state_d   = encoding_q ? S_PARITY : S_WAIT_RS;
                    end
                end
            end
            S_PARITY: begin
                // Pulses alternate with idle cycles; the idle cycle returns the parity byte on the sink.
                if (!syn_valid_q) begin
                    if (par_cnt_q != PAR_END) begin
                        syn_valid_d = 1'b1;
                        par_pulse_d = 1'b1;
                        par_cnt_d   = par_cnt_q + PAR_W'(1);
                    end else begin
                        end_segment = 1'b1;
                    end
                end
            end
            S_WAIT_RS: begin
                end_segment = rsDone;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (end_segment) begin
            if (seg_idx_q == LAST_SEG) begin
                state_d = S_DONE;
            end else begin
                state_d    = S_SEG_ENTRY;
                seg_idx_d  = seg_idx_q + 2'd1;
                gap_cnt_d  = '0;
                byte_cnt_d = '0;
                par_cnt_d  = '0;
            end
        end

        // Abort overrides everything, including a simultaneous start or handshake.
        if (abort) begin
            state_d     = S_IDLE;
            gap_cnt_d   = '0;
            byte_cnt_d  = '0;
            par_cnt_d   = '0;
            seg_idx_d   = 2'd0;
            encoding_d  = 1'b0;
            syn_valid_d = 1'b0;
            syn_data_d  = 8'h00;
            syn_blank_d = 1'b0;
            syn_end_d   = 1'b0;
            par_pulse_d = 1'b0;
            sink_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gap_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            par_cnt_q   <= '0;
            seg_idx_q   <= 2'd0;
            encoding_q  <= 1'b0;
            syn_valid_q <= 1'b0;
            syn_data_q  <= 8'h00;
            syn_blank_q <= 1'b0;
            syn_end_q   <= 1'b0;
            par_pulse_q <= 1'b0;
            sink_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            par_cnt_q   <= par_cnt_d;
            seg_idx_q   <= seg_idx_d;
            encoding_q  <= encoding_d;
            syn_valid_q <= syn_valid_d;
            syn_data_q  <= syn_data_d;
            syn_blank_q <= syn_blank_d;
            syn_end_q   <= syn_end_d;
            par_pulse_q <= par_pulse_d;
            sink_vld_q  <= sink_vld_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign synRunning    = busy & ~done;
    assign segIndex      = seg_idx_q;
    assign synEncoding   = encoding_q;
    assign synValid      = syn_valid_q;
    assign synDataI      = syn_data_q;
    assign synBlanking   = syn_blank_q;
    assign synEndSegment = syn_end_q;
    // A byte handshaked in an abort cycle is dropped, so do not advertise ready then.
    assign srcReady      = src_rdy & ~abort;
    assign sinkValid     = sink_vld_q;
    // The encoder presents parity the cycle after the request; pass it through only in that cycle.
    assign sinkData      = sink_vld_q ? synDataO : 8'h00;

`ifdef RS_SEQ_STATS_EN
    logic [15:0] byte_count_q, byte_count_d;
    logic [7:0]  seg_count_q, seg_count_d;
    logic        data_issue;
    logic        seg_complete;

    always_comb begin
        data_issue   = syn_valid_q & ~par_pulse_q;
        // PARITY/WAIT_RS are only left by finishing the segment or by abort.
        seg_complete = ((state_q == S_PARITY) || (state_q == S_WAIT_RS)) &&
                       (state_d != state_q) && !abort;
        byte_count_d = byte_count_q;
        seg_count_d  = seg_count_q;
        if (data_issue && (byte_count_q != 16'hFFFF)) begin
            byte_count_d = byte_count_q + 16'd1;
        end
        if (seg_complete && (seg_count_q != 8'hFF)) begin
            seg_count_d = seg_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count_q <= 16'd0;
            seg_count_q  <= 8'd0;
        end else begin
            byte_count_q <= byte_count_d;
            seg_count_q  <= seg_count_d;
        end
    end

    assign byteCount = byte_count_q;
    assign segCount  = seg_count_q;
`endif

endmodule

// File: tb/tb_rs_segment_sequencer.sv
// Purpose : self-checking bench for rs_segment_sequencer (job table + scoreboard of issued bytes).
// Latency : expects issue one cycle after handshake, DATA entry GAP+1 cycles after start/rsDone.
// Backpressure: source stalls and rsDone delays are driven from the job table.
module tb_rs_segment_sequencer;
    localparam int DATA_LEN = 172;
    localparam int PAR_LEN  = 4;
    localparam int SEG_NUM  = 3;
    localparam int GAP      = 3;

    logic       clk = 1'b0;
    logic       reset, start, encode, abort;
    logic       busy, done;
    logic [1:0] segIndex;
    logic [7:0] srcData;
    logic       srcBlank, srcValid, srcReady;
    logic [7:0] sinkData;
    logic       sinkValid;
    logic       synRunning, synEncoding, synEndSegment, synValid, synBlanking;
    logic [7:0] synDataI, synDataO;
    logic       rsDone;
`ifdef RS_SEQ_STATS_EN
    logic [15:0] byteCount;
    logic [7:0]  segCount;
`endif

    always #5 clk = ~clk;

    rs_segment_sequencer #(
        .DATA_LEN(DATA_LEN), .PAR_LEN(PAR_LEN), .SEG_NUM(SEG_NUM), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .encode(encode), .abort(abort),
        .busy(busy), .done(done), .segIndex(segIndex),
        .srcData(srcData), .srcBlank(srcBlank), .srcValid(srcValid), .srcReady(srcReady),
        .sinkData(sinkData), .sinkValid(sinkValid),
        .synRunning(synRunning), .synEncoding(synEncoding), .synEndSegment(synEndSegment),
        .synDataI(synDataI), .synValid(synValid), .synBlanking(synBlanking),
        .synDataO(synDataO), .rsDone(rsDone)
`ifdef RS_SEQ_STATS_EN
        , .byteCount(byteCount), .segCount(segCount)
`endif
    );

    typedef struct {
        bit enc;
        int stall_at;   // bytes accepted before a 10-cycle srcValid gap
        int blank_lo;   // 1-based job byte numbers carrying srcBlank
        int blank_hi;
        int start_at;   // bytes accepted before a stray start pulse
        int abort_at;   // job byte number whose handshake cycle carries abort/reset
        bit by_reset;
        int exp_data;
        int exp_sink;
        int exp_done;
        int exp_ends;
        int exp_blank;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       blank;
        logic       endseg;
        logic [1:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic [7:0] drv_o;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run_job(input vec_t v, input int vi);
        int len, acc, seg, seg_byte, cyc, ref_cyc, par_left, rs_timer, stall_left;
        int n_data, n_sink, n_done, n_ends, n_blank;
        bit fin, aborted, prev_par, cur_par, expect_rdy, stalled, stray, start_pulsed, hs;
        exp_t e;
        len = v.enc ? DATA_LEN : DATA_LEN + PAR_LEN;
        acc = 0; seg = 0; seg_byte = 0; par_left = 0; rs_timer = 0; stall_left = 0;
        n_data = 0; n_sink = 0; n_done = 0; n_ends = 0; n_blank = 0;
        fin = 0; aborted = 0; prev_par = 0; stalled = 0; stray = 0; start_pulsed = 0;
        sb.delete();

        srcValid = 1'b0;
        start    = 1'b1;
        encode   = v.enc;
        @(posedge clk); #1;
        cyc = 1;
        start = 1'b0;
        encode = ~v.enc;   // must not matter after start
        ref_cyc = 0;
        expect_rdy = 1;

        while (!fin && cyc < 5000) begin
            // ---- observe ----
            cur_par = 0;
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                check("running_in_gap", synRunning, 1);
                check("encoding_latched", synEncoding, v.enc);
            end
            if (sinkValid || prev_par) check("sink_valid", sinkValid, prev_par);
            if (sinkValid) begin
                n_sink++;
                check("sink_data", sinkData, drv_o);
            end
            if (synValid) begin
                check("ready_in_issue", srcReady, 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_data++;
                    check("syn_data", synDataI, e.data);
                    check("syn_blank", synBlanking, e.blank);
                    check("syn_end", synEndSegment, e.endseg);
                    check("seg_index", segIndex, e.seg);
                    if (e.endseg) begin
                        if (v.enc) par_left = PAR_LEN;
                        else rs_timer = 40;
                    end
                end else if (par_left > 0) begin
                    check("parity_data", synDataI, 0);
                    check("parity_blank", synBlanking, 0);
                    check("parity_end", synEndSegment, 0);
                    par_left--;
                    cur_par = 1;
                end else begin
                    check("unexpected_syn_valid", 1, 0);
                end
            end
            if (synEndSegment) n_ends++;
            if (synBlanking) n_blank++;
            prev_par = cur_par;
            if (expect_rdy && srcReady) begin
                check("gap_latency", cyc - ref_cyc, GAP + 1);
                expect_rdy = 0;
            end
            if (done) begin
                n_done++;
                check("running_in_done", synRunning, 0);
                fin = 1;
            end

            if (!fin) begin
                // ---- drive ----
                rsDone = 1'b0;
                start  = 1'b0;
                if (!v.enc && acc == 50 && !stray) begin
                    rsDone = 1'b1;      // outside WAIT_RS: must be ignored
                    stray  = 1;
                end
                if (rs_timer > 0) begin
                    rs_timer--;
                    if (rs_timer == 0) begin
                        rsDone  = 1'b1;
                        ref_cyc = cyc;
                        if (seg < SEG_NUM) expect_rdy = 1;
                    end
                end
                if (acc == v.start_at && !start_pulsed) begin
                    start = 1'b1;
                    start_pulsed = 1;
                end
                if (!stalled && acc == v.stall_at) begin
                    stall_left = 10;
                    stalled = 1;
                end
                srcValid = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                srcData  = 8'(acc * 37 + vi * 11 + 5);
                srcBlank = (acc + 1 >= v.blank_lo) && (acc + 1 <= v.blank_hi);
                drv_o    = 8'($urandom);
                synDataO = drv_o;
                hs = srcValid && srcReady;
                if (hs && v.abort_at > 0 && acc + 1 == v.abort_at) begin
                    if (v.by_reset) reset = 1'b1;
                    else abort = 1'b1;
                    aborted = 1;
                    hs = 0;
                end
                if (hs) begin
                    e.data = srcData; e.blank = srcBlank;
                    e.endseg = (seg_byte + 1 == len); e.seg = 2'(seg);
                    sb.push_back(e);
                    acc++;
                    seg_byte++;
                    if (seg_byte == len) begin
                        seg_byte = 0;
                        seg++;
                    end
                end
                @(posedge clk); #1;
                cyc++;
                if (aborted) begin
                    abort = 1'b0;
                    reset = 1'b0;
                    srcValid = 1'b0;
                    rsDone = 1'b0;
                    check("abort_busy", busy, 0);
                    check("abort_syn_valid", synValid, 0);
                    check("abort_seg_index", segIndex, 0);
                    check("abort_encoding", synEncoding, 0);
                    check("abort_running", synRunning, 0);
                    check("abort_sink_valid", sinkValid, 0);
                    repeat (6) begin
                        if (done) n_done++;
                        @(posedge clk); #1;
                    end
                    fin = 1;
                end
            end
        end

        srcValid = 1'b0;
        rsDone   = 1'b0;
        start    = 1'b0;
        if (!fin) begin
            check("job_timeout", 0, 1);
        end else if (!aborted) begin
            @(posedge clk); #1;
            check("idle_after_done_busy", busy, 0);
            check("done_single_pulse", done, 0);
        end
        check("data_pulses", n_data, v.exp_data);
        check("sink_pulses", n_sink, v.exp_sink);
        check("done_pulses", n_done, v.exp_done);
        check("end_segments", n_ends, v.exp_ends);
        check("blank_pulses", n_blank, v.exp_blank);
        check("scoreboard_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, -1,   0,  -1,  -1,  -1, 0, 516, 12, 1, 3, 0};  // plain encode
        vecs[1] = '{0, -1, 520, 523, 200,  -1, 0, 528,  0, 1, 3, 4};  // decode, erasures, stray start
        vecs[2] = '{1, 300,  0,  -1,  -1,  -1, 0, 516, 12, 1, 3, 0};  // source stall mid-segment
        vecs[3] = '{1, -1,   0,  -1,  -1, 272, 0, 271,  4, 0, 1, 0};  // abort on byte 100 of seg 1
        vecs[4] = '{1, -1, 172, 173,  -1,  -1, 0, 516, 12, 1, 3, 2};  // full job after abort
        vecs[5] = '{0, -1,   0,  -1,  -1,  10, 1,   9,  0, 0, 0, 0};  // reset mid-job
        vecs[6] = '{0, 180,  0,  -1,  50,  -1, 0, 528,  0, 1, 3, 0};  // decode with stall

        reset = 1'b1; start = 1'b0; encode = 1'b1; abort = 1'b0;
        srcData = 8'h5A; srcBlank = 1'b1; srcValid = 1'b1; rsDone = 1'b0;
        drv_o = 8'hA5; synDataO = drv_o;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_seg_index", segIndex, 0);
        check("rst_src_ready", srcReady, 0);
        check("rst_sink_data", sinkData, 0);
        check("rst_sink_valid", sinkValid, 0);
        check("rst_running", synRunning, 0);
        check("rst_encoding", synEncoding, 0);
        check("rst_end_segment", synEndSegment, 0);
        check("rst_syn_data", synDataI, 0);
        check("rst_syn_valid", synValid, 0);
        check("rst_blanking", synBlanking, 0);
        reset = 1'b0; srcValid = 1'b0; srcBlank = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_job(vecs[i], i);

        // abort wins over a simultaneous start in IDLE
        start = 1'b1; encode = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start_busy", busy, 0);
        check("abort_beats_start_encoding", synEncoding, 0);
        @(posedge clk); #1;
        check("abort_beats_start_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
